// File: rtl/video_sync_pkg.sv
// Shared types and helpers for the video timing controller.
// Both axes (horizontal and vertical) use the same four-phase state type.
package video_sync_pkg;

  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } sync_st_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync_w, input int bp);
    return active + fp + sync_w + bp;
  endfunction

  // Maps an internal active-high sync to its pin level for the given polarity.
  function automatic logic sync_pin(input logic active, input logic pol);
    return pol ? active : ~active;
  endfunction

endpackage

// File: rtl/sync_axis_timer.sv
// One timing axis: a position counter plus the ACT/FP/SYNC/BP phase machine.
// Exposes both the registered values and the values loaded at the next edge.
module sync_axis_timer
  import video_sync_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         CK,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic [1:0]   state,
  output logic [1:0]   state_nxt,
  output logic         wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] END_ACT  = W'(ACTIVE - 1);
  localparam logic [W-1:0] END_FP   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] END_SYNC = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] END_BP   = W'(TOTAL - 1);

  sync_st_t     st_q, st_d;
  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = (cnt_q == END_BP);

  // Each phase ends on the last position it owns, so the phase change and
  // the counter step land on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    st_d  = st_q;
    if (clear) begin
      cnt_d = '0;
      st_d  = ST_ACT;
    end else if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      case (st_q)
        ST_ACT:  if (cnt_q == END_ACT)  st_d = ST_FP;
        ST_FP:   if (cnt_q == END_FP)   st_d = ST_SYNC;
        ST_SYNC: if (cnt_q == END_SYNC) st_d = ST_BP;
        ST_BP:   if (wrap)              st_d = ST_ACT;
        default:                        st_d = ST_ACT;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    cnt_q <= cnt_d;
    st_q  <= st_d;
  end

  assign cnt       = cnt_q;
  assign cnt_nxt   = cnt_d;
  assign state     = st_q;
  assign state_nxt = st_d;

endmodule

// File: rtl/video_sync_gen.sv
// Video timing controller: owns H/V counters and produces sync, blank and
// line/frame strobes, all aligned to the registered hcnt/vcnt.
module video_sync_gen
  import video_sync_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HCNT_W   = 10,
  parameter int VCNT_W   = 10,
  parameter int SYNC_POL = 0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              en,
  input  logic              restart,
  output logic              hsync,
  output logic              vsync,
  output logic              csync,
  output logic              cblank,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              line_start,
  output logic              frame_start
);

  localparam int   H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic POL     = (SYNC_POL != 0);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("video_sync_gen: every horizontal segment must be at least 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("video_sync_gen: every vertical segment must be at least 1");
  end
  if (H_TOTAL - 1 >= (1 << HCNT_W)) begin : g_bad_hw
    $error("video_sync_gen: HCNT_W too narrow for H_TOTAL-1");
  end
  if (V_TOTAL - 1 >= (1 << VCNT_W)) begin : g_bad_vw
    $error("video_sync_gen: VCNT_W too narrow for V_TOTAL-1");
  end

  logic              clear;
  logic              h_wrap, v_wrap, v_step;
  logic [HCNT_W-1:0] h_cnt_nxt;
  logic [VCNT_W-1:0] v_cnt_nxt;
  logic [1:0]        h_state, v_state, h_state_nxt, v_state_nxt;
  logic              h_sync_nxt, v_sync_nxt, blank_nxt;
  logic              h_zero_q, f_zero_q;
  logic              unused_sig;

  assign clear  = RST | restart;
  assign v_step = en & h_wrap;

  sync_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HCNT_W)
  ) u_h_timer (
    .CK        (CK),
    .step      (en),
    .clear     (clear),
    .cnt       (hcnt),
    .cnt_nxt   (h_cnt_nxt),
    .state     (h_state),
    .state_nxt (h_state_nxt),
    .wrap      (h_wrap)
  );

  sync_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VCNT_W)
  ) u_v_timer (
    .CK        (CK),
    .step      (v_step),
    .clear     (clear),
    .cnt       (vcnt),
    .cnt_nxt   (v_cnt_nxt),
    .state     (v_state),
    .state_nxt (v_state_nxt),
    .wrap      (v_wrap)
  );

  assign unused_sig = ^{v_wrap, h_state, v_state};

  // Decode from the values the timers load on this edge, so the registered
  // sync/blank outputs change on the same edge as hcnt/vcnt.
  always_comb begin
    h_sync_nxt = (sync_st_t'(h_state_nxt) == ST_SYNC);
    v_sync_nxt = (sync_st_t'(v_state_nxt) == ST_SYNC);
    blank_nxt  = (sync_st_t'(h_state_nxt) != ST_ACT) |
                 (sync_st_t'(v_state_nxt) != ST_ACT);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      hsync    <= sync_pin(1'b0, POL);
      vsync    <= sync_pin(1'b0, POL);
      csync    <= sync_pin(1'b0, POL);
      cblank   <= 1'b0;
      h_zero_q <= 1'b1;
      f_zero_q <= 1'b1;
    end else begin
      hsync    <= sync_pin(h_sync_nxt, POL);
      vsync    <= sync_pin(v_sync_nxt, POL);
      csync    <= sync_pin(h_sync_nxt | v_sync_nxt, POL);
      cblank   <= blank_nxt;
      h_zero_q <= (h_cnt_nxt == '0);
      f_zero_q <= (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
    end
  end

  // A strobe marks the cycle pixel 0 is actually consumed; a held or
  // reloading counter must not repeat it.
  assign line_start  = h_zero_q & en & ~clear;
  assign frame_start = f_zero_q & en & ~clear;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: two instances (both sync polarities) driven in
// lockstep and compared against a position-based reference model.
module tb_video_sync_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int CW = 4;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b1;
  logic          restart = 1'b0;

  logic          hs1, vs1, cs1, cb1, ls1, fs1;
  logic [CW-1:0] hc1, vc1;
  logic          hs0, vs0, cs0, cb0, ls0, fs0;
  logic [CW-1:0] hc0, vc0;

  int n_vec = 0;
  int n_err = 0;
  int mh = 0;
  int mv = 0;
  int fs_cnt = 0, ls_cnt = 0, vs_cnt = 0, hs_cnt = 0, cb_cnt = 0;

  always #5 CK = ~CK;

  video_sync_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HCNT_W (CW), .VCNT_W (CW), .SYNC_POL (1)
  ) u_dut_p1 (
    .CK (CK), .RST (RST), .en (en), .restart (restart),
    .hsync (hs1), .vsync (vs1), .csync (cs1), .cblank (cb1),
    .hcnt (hc1), .vcnt (vc1), .line_start (ls1), .frame_start (fs1)
  );

  video_sync_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HCNT_W (CW), .VCNT_W (CW), .SYNC_POL (0)
  ) u_dut_p0 (
    .CK (CK), .RST (RST), .en (en), .restart (restart),
    .hsync (hs0), .vsync (vs0), .csync (cs0), .cblank (cb0),
    .hcnt (hc0), .vcnt (vc0), .line_start (ls0), .frame_start (fs0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  // Expected outputs follow directly from the model position and the inputs.
  task automatic check_outputs();
    logic h_s, v_s, blank, ls, fs;
    h_s   = (mh >= HA + HF) && (mh < HA + HF + HS);
    v_s   = (mv >= VA + VF) && (mv < VA + VF + VS);
    blank = (mh >= HA) || (mv >= VA);
    ls    = en && !RST && !restart && (mh == 0);
    fs    = ls && (mv == 0);
    chk("hcnt_p1", 32'(hc1), 32'(mh));
    chk("vcnt_p1", 32'(vc1), 32'(mv));
    chk("hsync_p1", 32'(hs1), 32'(h_s));
    chk("vsync_p1", 32'(vs1), 32'(v_s));
    chk("csync_p1", 32'(cs1), 32'(h_s | v_s));
    chk("cblank_p1", 32'(cb1), 32'(blank));
    chk("line_start_p1", 32'(ls1), 32'(ls));
    chk("frame_start_p1", 32'(fs1), 32'(fs));
    chk("hcnt_p0", 32'(hc0), 32'(mh));
    chk("vcnt_p0", 32'(vc0), 32'(mv));
    chk("hsync_p0", 32'(hs0), 32'(!h_s));
    chk("vsync_p0", 32'(vs0), 32'(!v_s));
    chk("csync_p0", 32'(cs0), 32'(!(h_s | v_s)));
    chk("cblank_p0", 32'(cb0), 32'(blank));
    chk("line_start_p0", 32'(ls0), 32'(ls));
    chk("frame_start_p0", 32'(fs0), 32'(fs));
  endtask

  task automatic cycle(input logic e, input logic rs, input logic r);
    @(negedge CK);
    en = e;
    restart = rs;
    RST = r;
    #1;
    check_outputs();
    fs_cnt += int'(fs1);
    ls_cnt += int'(ls1);
    vs_cnt += int'(vs1);
    hs_cnt += int'(hs1);
    cb_cnt += int'(cb1);
    @(posedge CK);
    if (r || rs) begin
      mh = 0;
      mv = 0;
    end else if (e) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  task automatic clear_tallies();
    fs_cnt = 0; ls_cnt = 0; vs_cnt = 0; hs_cnt = 0; cb_cnt = 0;
  endtask

  task automatic run_to(input int th, input int tv);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (mh == th && mv == tv) break;
      cycle(1'b1, 1'b0, 1'b0);
    end
    #1;
    chk("reach_hcnt", 32'(hc1), 32'(th));
    chk("reach_vcnt", 32'(vc1), 32'(tv));
  endtask

  initial begin
    // Reset for three cycles with en high, then one line of counting.
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    clear_tallies();
    repeat (HT) cycle(1'b1, 1'b0, 1'b0);
    chk("line0_hsync_cycles", 32'(hs_cnt), 32'(HS));
    chk("line0_cblank_cycles", 32'(cb_cnt), 32'(HB + HS + HF));
    chk("line0_line_start", 32'(ls_cnt), 32'd1);

    // Remainder of the first frame plus a full second frame window.
    repeat (HT * VT - HT) cycle(1'b1, 1'b0, 1'b0);
    clear_tallies();
    repeat (HT * VT) cycle(1'b1, 1'b0, 1'b0);
    chk("frame_start_per_frame", 32'(fs_cnt), 32'd1);
    chk("vsync_cycles_per_frame", 32'(vs_cnt), 32'(VS * HT));
    chk("line_start_per_frame", 32'(ls_cnt), 32'(VT));

    // Stall mid-line, then resume.
    run_to(3, 2);
    clear_tallies();
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    chk("stall_line_start", 32'(ls_cnt), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // Restart from inside the vertical sync line.
    run_to(6, 4);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (HT + 2) cycle(1'b1, 1'b0, 1'b0);

    // Stall at pixel 0 of a line: the strobe must not repeat while held.
    run_to(0, 1);
    clear_tallies();
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("held_zero_line_start", 32'(ls_cnt), 32'd1);

    // Reset together with restart and en low, mid-frame.
    run_to(2, 3);
    clear_tallies();
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("post_reset_frame_start_idle", 32'(fs_cnt), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("post_reset_frame_start_first", 32'(fs_cnt), 32'd1);

    // Randomised enable, restart and reset traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 59) == 0),
            logic'($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
